// File: rtl/conv_window_addr_gen_if.sv
// Window address stream between the layer controller/feature buffer and the generator.
// The master side is the address generator; the slave side is the controller/consumer.
interface conv_window_addr_gen_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int PORT_NUM   = 25
);
   logic                             start;
   logic                             abort;
   logic                             out_ready;
   logic                             out_valid;
   logic [PORT_NUM*ADDR_WIDTH-1:0]   out_addr;
   logic [7:0]                       out_depth;
   logic [15:0]                      out_row;
   logic [15:0]                      out_col;
   logic                             out_last;
   logic                             busy;
   logic                             done;

   modport master (
      input  start, abort, out_ready,
      output out_valid, out_addr, out_depth, out_row, out_col, out_last, busy, done
   );

   modport slave (
      output start, abort, out_ready,
      input  out_valid, out_addr, out_depth, out_row, out_col, out_last, busy, done
   );
endinterface

// File: rtl/conv_window_addr_gen.sv
// Convolution window address generator: one window of KERNAL_HEIGHT*KERNAL_WIDTH
// linear addresses per handshake, scanning column, then row, then depth.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | presenting a window, out_valid high
// S_DONE | one-cycle done pulse after the final handshake
module conv_window_addr_gen #(
   parameter int          ADDR_WIDTH    = 16,
   parameter int          DATA_HEIGHT   = 35,
   parameter int          DATA_WIDTH    = 35,
   parameter int          DATA_DEPTH    = 1,
   parameter int          KERNAL_HEIGHT = 5,
   parameter int          KERNAL_WIDTH  = 5,
   parameter int          STRIDE        = 1,
   parameter int unsigned BASE_ADDR     = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   conv_window_addr_gen_if.master   bus
);
   localparam int PORT_NUM = KERNAL_HEIGHT * KERNAL_WIDTH;
   localparam int OUT_W    = (DATA_WIDTH - KERNAL_WIDTH) / STRIDE + 1;
   localparam int OUT_H    = (DATA_HEIGHT - KERNAL_HEIGHT) / STRIDE + 1;

   localparam logic [15:0]           LAST_COL   = 16'((OUT_W - 1) * STRIDE);
   localparam logic [15:0]           LAST_ROW   = 16'((OUT_H - 1) * STRIDE);
   localparam logic [7:0]            LAST_DEPTH = 8'(DATA_DEPTH - 1);
   localparam logic [15:0]           STEP       = 16'(STRIDE);
   localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(STRIDE * DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] PLANE_STEP = ADDR_WIDTH'(DATA_HEIGHT * DATA_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                         state_q, state_d;
   logic [15:0]                    row_q, row_d;
   logic [15:0]                    col_q, col_d;
   logic [7:0]                     depth_q, depth_d;
   logic [ADDR_WIDTH-1:0]          row_base_q, row_base_d;
   logic [ADDR_WIDTH-1:0]          depth_base_q, depth_base_d;
   logic [PORT_NUM*ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                           last_q, last_d;
   logic                           valid_q, valid_d;
   logic                           done_q, done_d;
   logic                           load;
   logic                           advance;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         depth_q      <= '0;
         row_base_q   <= '0;
         depth_base_q <= '0;
         addr_q       <= '0;
         last_q       <= 1'b0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         depth_q      <= depth_d;
         row_base_q   <= row_base_d;
         depth_base_q <= depth_base_d;
         addr_q       <= addr_d;
         last_q       <= last_d;
         valid_q      <= valid_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      depth_d      = depth_q;
      row_base_d   = row_base_q;
      depth_base_d = depth_base_q;
      addr_d       = addr_q;
      last_d       = last_q;
      load         = 1'b0;
      advance      = 1'b0;

      // abort outranks both start and a pending handshake
      case (state_q)
         S_IDLE: begin
            if (!bus.abort && bus.start) begin
               state_d = S_RUN;
               load    = 1'b1;
            end
         end
         S_RUN: begin
            if (bus.abort) begin
               state_d = S_IDLE;
               last_d  = 1'b0;
            end else if (bus.out_ready) begin
               if (last_q) begin
                  state_d = S_DONE;
                  last_d  = 1'b0;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         row_d        = '0;
         col_d        = '0;
         depth_d      = '0;
         row_base_d   = BASE;
         depth_base_d = BASE;
      end else if (advance) begin
         if (col_q != LAST_COL) begin
            col_d = col_q + STEP;
         end else begin
            col_d = '0;
            if (row_q != LAST_ROW) begin
               row_d      = row_q + STEP;
               row_base_d = row_base_q + ROW_STEP;
            end else begin
               row_d        = '0;
               depth_d      = depth_q + 8'd1;
               depth_base_d = depth_base_q + PLANE_STEP;
               row_base_d   = depth_base_q + PLANE_STEP;
            end
         end
      end

      // port offsets i*DATA_WIDTH+j are elaboration constants, so only adders remain
      if (load || advance) begin
         last_d = (col_d == LAST_COL) && (row_d == LAST_ROW) && (depth_d == LAST_DEPTH);
         for (int p = 0; p < PORT_NUM; p++) begin
            addr_d[p*ADDR_WIDTH +: ADDR_WIDTH] = row_base_d + ADDR_WIDTH'(col_d)
               + ADDR_WIDTH'((p / KERNAL_WIDTH) * DATA_WIDTH + (p % KERNAL_WIDTH));
         end
      end

      valid_d = (state_d == S_RUN);
      done_d  = (state_d == S_DONE);
   end

   assign bus.out_valid = valid_q;
   assign bus.busy      = valid_q;
   assign bus.done      = done_q;
   assign bus.out_addr  = addr_q;
   assign bus.out_depth = depth_q;
   assign bus.out_row   = row_q;
   assign bus.out_col   = col_q;
   assign bus.out_last  = last_q;
endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Scoreboard bench: three generator configurations, expected windows queued at start,
// popped and compared on each handshake.
module tb_conv_window_addr_gen;
   localparam int AW = 16;
   localparam int PN = 9;

   typedef struct {
      logic [PN*AW-1:0] addr;
      logic [7:0]       depth;
      logic [15:0]      row;
      logic [15:0]      col;
      logic             last;
   } win_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic ready = 1'b0;
   int   sel = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   win_t sb[$];

   always #5 clk = ~clk;

   conv_window_addr_gen_if #(.ADDR_WIDTH(AW), .PORT_NUM(PN)) ia ();
   conv_window_addr_gen_if #(.ADDR_WIDTH(AW), .PORT_NUM(PN)) ib ();
   conv_window_addr_gen_if #(.ADDR_WIDTH(AW), .PORT_NUM(PN)) ic ();

   assign ia.start     = start && (sel == 0);
   assign ia.abort     = abort && (sel == 0);
   assign ia.out_ready = ready && (sel == 0);
   assign ib.start     = start && (sel == 1);
   assign ib.abort     = abort && (sel == 1);
   assign ib.out_ready = ready && (sel == 1);
   assign ic.start     = start && (sel == 2);
   assign ic.abort     = abort && (sel == 2);
   assign ic.out_ready = ready && (sel == 2);

   conv_window_addr_gen #(.ADDR_WIDTH(AW), .DATA_HEIGHT(6), .DATA_WIDTH(6), .DATA_DEPTH(2),
      .KERNAL_HEIGHT(3), .KERNAL_WIDTH(3), .STRIDE(1), .BASE_ADDR(0))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   conv_window_addr_gen #(.ADDR_WIDTH(AW), .DATA_HEIGHT(7), .DATA_WIDTH(7), .DATA_DEPTH(1),
      .KERNAL_HEIGHT(3), .KERNAL_WIDTH(3), .STRIDE(2), .BASE_ADDR(0))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
   conv_window_addr_gen #(.ADDR_WIDTH(AW), .DATA_HEIGHT(6), .DATA_WIDTH(6), .DATA_DEPTH(2),
      .KERNAL_HEIGHT(3), .KERNAL_WIDTH(3), .STRIDE(1), .BASE_ADDR(32'hFFF0))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

   logic             obs_valid, obs_last, obs_busy, obs_done;
   logic [PN*AW-1:0] obs_addr;
   logic [7:0]       obs_depth;
   logic [15:0]      obs_row, obs_col;
   logic [191:0]     obs_bundle;

   always_comb begin
      obs_valid = ia.out_valid;
      obs_last  = ia.out_last;
      obs_busy  = ia.busy;
      obs_done  = ia.done;
      obs_addr  = ia.out_addr;
      obs_depth = ia.out_depth;
      obs_row   = ia.out_row;
      obs_col   = ia.out_col;
      if (sel == 1) begin
         obs_valid = ib.out_valid;
         obs_last  = ib.out_last;
         obs_busy  = ib.busy;
         obs_done  = ib.done;
         obs_addr  = ib.out_addr;
         obs_depth = ib.out_depth;
         obs_row   = ib.out_row;
         obs_col   = ib.out_col;
      end else if (sel == 2) begin
         obs_valid = ic.out_valid;
         obs_last  = ic.out_last;
         obs_busy  = ic.busy;
         obs_done  = ic.done;
         obs_addr  = ic.out_addr;
         obs_depth = ic.out_depth;
         obs_row   = ic.out_row;
         obs_col   = ic.out_col;
      end
   end

   assign obs_bundle = {6'd0, obs_addr, obs_depth, obs_row, obs_col, obs_last, obs_valid};

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference windows straight from the address formula
   task automatic push_scan(input int h, input int w, input int d, input int k,
                            input int s, input int base);
      int ow;
      int oh;
      int a;
      win_t e;
      ow = (w - k) / s + 1;
      oh = (h - k) / s + 1;
      for (int dd = 0; dd < d; dd++)
         for (int r = 0; r < oh; r++)
            for (int c = 0; c < ow; c++) begin
               e.addr  = '0;
               e.depth = 8'(dd);
               e.row   = 16'(r * s);
               e.col   = 16'(c * s);
               e.last  = (dd == d - 1) && (r == oh - 1) && (c == ow - 1);
               for (int p = 0; p < k * k; p++) begin
                  a = base + dd * h * w + (r * s + p / k) * w + c * s + p % k;
                  e.addr[p*AW +: AW] = 16'(a);
               end
               sb.push_back(e);
            end
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_valid", 192'(obs_valid), 192'(1'b1));
      check("start_busy", 192'(obs_busy), 192'(1'b1));
   endtask

   // Handshakes are decided at the negedge: outputs seen now are what the next posedge takes.
   task automatic consume(input bit rnd, input bit poke_start, input int max_hs, input int budget);
      int           hs;
      bit           stalled;
      logic [191:0] held;
      win_t         e;
      hs = 0;
      stalled = 1'b0;
      held = '0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         if (stalled) check("stall_hold", obs_bundle, held);
         if (hs == max_hs) return;
         check("no_early_done", 192'(obs_done), 192'(1'b0));
         ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke_start) start = 1'($urandom_range(0, 1));
         if (obs_valid && ready) begin
            if (sb.size() == 0) begin
               check("extra_window", 192'(obs_valid), 192'(1'b0));
               ready = 1'b0;
               start = 1'b0;
               return;
            end
            e = sb.pop_front();
            check("addr", 192'(obs_addr), 192'(e.addr));
            check("depth", 192'(obs_depth), 192'(e.depth));
            check("row", 192'(obs_row), 192'(e.row));
            check("col", 192'(obs_col), 192'(e.col));
            check("last", 192'(obs_last), 192'(e.last));
            hs++;
            stalled = 1'b0;
            if (obs_last) begin
               check("sb_empty_at_last", 192'(sb.size()), 192'(0));
               @(negedge clk);
               ready = 1'b0;
               start = 1'b0;
               check("done_pulse", 192'(obs_done), 192'(1'b1));
               check("done_valid_low", 192'(obs_valid), 192'(1'b0));
               check("done_busy_low", 192'(obs_busy), 192'(1'b0));
               @(negedge clk);
               check("done_once", 192'(obs_done), 192'(1'b0));
               check("idle_valid_low", 192'(obs_valid), 192'(1'b0));
               return;
            end
         end else begin
            stalled = obs_valid;
            held = obs_bundle;
         end
         @(negedge clk);
      end
      ready = 1'b0;
      start = 1'b0;
      check("timeout_windows_left", 192'(sb.size()), 192'(0));
   endtask

   initial begin
      #1;
      check("reset_bundle", obs_bundle, 192'(0));
      check("reset_busy", 192'(obs_busy), 192'(1'b0));
      check("reset_done", 192'(obs_done), 192'(1'b0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // basic scan, 32 windows
      sel = 0;
      push_scan(6, 6, 2, 3, 1, 0);
      do_start();
      check("basic_w0_port0", 192'(obs_addr[0 +: AW]), 192'(16'd0));
      check("basic_w0_port8", 192'(obs_addr[8*AW +: AW]), 192'(16'd14));
      consume(1'b0, 1'b0, -1, 200);

      // stride 2, 3x3 windows
      sel = 1;
      push_scan(7, 7, 1, 3, 2, 0);
      do_start();
      consume(1'b0, 1'b0, -1, 100);

      // random backpressure
      sel = 0;
      push_scan(6, 6, 2, 3, 1, 0);
      do_start();
      consume(1'b1, 1'b0, -1, 2000);

      // abort at window 10, which outranks the simultaneous handshake
      push_scan(6, 6, 2, 3, 1, 0);
      do_start();
      consume(1'b0, 1'b0, 10, 200);
      check("abort_w10_row", 192'(obs_row), 192'(16'd2));
      check("abort_w10_col", 192'(obs_col), 192'(16'd2));
      ready = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      ready = 1'b0;
      check("abort_valid", 192'(obs_valid), 192'(1'b0));
      check("abort_busy", 192'(obs_busy), 192'(1'b0));
      check("abort_no_done", 192'(obs_done), 192'(1'b0));
      @(negedge clk);
      check("abort_no_done_late", 192'(obs_done), 192'(1'b0));
      sb.delete();
      push_scan(6, 6, 2, 3, 1, 0);
      do_start();
      check("restart_port0", 192'(obs_addr[0 +: AW]), 192'(16'd0));
      consume(1'b0, 1'b0, -1, 200);

      // async reset between edges mid-scan
      push_scan(6, 6, 2, 3, 1, 0);
      do_start();
      consume(1'b0, 1'b0, 7, 200);
      ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_bundle", obs_bundle, 192'(0));
      check("async_rst_busy", 192'(obs_busy), 192'(1'b0));
      check("async_rst_done", 192'(obs_done), 192'(1'b0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      push_scan(6, 6, 2, 3, 1, 0);
      do_start();
      consume(1'b0, 1'b0, -1, 200);

      // address wrap with start pulses during RUN
      sel = 2;
      push_scan(6, 6, 2, 3, 1, 32'hFFF0);
      do_start();
      check("wrap_w0_port8", 192'(obs_addr[8*AW +: AW]), 192'(16'hFFFE));
      consume(1'b0, 1'b1, -1, 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
